// File: rtl/binary_bcd_pkg.sv
// -----------------------------------------------------------------------------
// binary_bcd_pkg
// Shared constants and types for the 5-bit binary-to-BCD converter.
//   IN_W      : width of the binary input
//   OUT_W     : width of the packed BCD result {tens[0], units[3:0]}
//   ITER      : number of shift-and-add-3 iterations (one per input bit)
//   CNT_W     : width of the iteration counter
//   SAT_VALUE : result driven when the input cannot be shown in two digits
// -----------------------------------------------------------------------------
package binary_bcd_pkg;

   localparam int IN_W  = 5;
   localparam int OUT_W = 5;
   localparam int ITER  = 5;
   localparam int CNT_W = 3;

   // Decimal 19: tens = 1, units = 9.
   localparam logic [OUT_W-1:0] SAT_VALUE = 5'b1_1001;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage : binary_bcd_pkg

// File: rtl/binary_bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble nibble corrector: adds 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit.
//   digit_i : BCD digit before correction
//   digit_o : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Add-3-if-at-least-5 correction.
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end else begin
         digit_o = digit_i;
      end
   end

endmodule : bcd_digit_adj

// File: rtl/binary_bcd.sv
// -----------------------------------------------------------------------------
// binary_bcd
// Sequential 5-bit binary to two-digit BCD converter (shift-and-add-3).
// A value is taken on a valid/ready handshake, converted over five SHIFT
// cycles, and returned with a one-cycle out_valid pulse. Inputs of 20 and above
// saturate the result to 19 and raise ovf.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : request to convert inp
//   inp       : binary value 0..31
//   ready     : high when a request can be accepted
//   out_valid : one-cycle pulse marking a new result
//   out       : {tens digit (0/1), units digit (0..9)}, held until next result
//   ovf       : input was 20 or more, held with out
// -----------------------------------------------------------------------------
module binary_bcd
   import binary_bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  inp,
   output logic             ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out,
   output logic             ovf
);

   state_e             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [1:0]         tens_q,      tens_d;
   logic [3:0]         units_q,     units_d;
   logic [IN_W-1:0]    bin_q,       bin_d;
   logic               ready_q,     ready_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_q,       out_d;
   logic               ovf_q,       ovf_d;

   logic [3:0]         units_adj_s;
   logic [3:0]         tens_adj_s;
   logic [3:0]         units_next_s;
   logic [4:0]         tens_next_s;
   logic [IN_W-1:0]    bin_next_s;
   logic               ovf_next_s;

   bcd_digit_adj u_units_adj (
      .digit_i (units_q),
      .digit_o (units_adj_s)
   );

   // Tens digit only ever holds 0..3; zero-extend it into a full nibble.
   bcd_digit_adj u_tens_adj (
      .digit_i ({2'b00, tens_q}),
      .digit_o (tens_adj_s)
   );

   // One shift of {tens, units, bin} after digit correction. tens_next_s keeps
   // all the bits that come out of the tens corrector so saturation can look at
   // the full value, even though only two bits are stored.
   always_comb begin
      units_next_s = {units_adj_s[2:0], bin_q[IN_W-1]};
      tens_next_s  = {tens_adj_s, units_adj_s[3]};
      bin_next_s   = {bin_q[IN_W-2:0], 1'b0};
      ovf_next_s   = (tens_next_s >= 5'd2);
   end

   // Next-state logic for the FSM, datapath and registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tens_d      = tens_q;
      units_d     = units_q;
      bin_d       = bin_q;
      ready_d     = ready_q;
      out_valid_d = 1'b0;
      out_d       = out_q;
      ovf_d       = ovf_q;

      case (state_q)
         IDLE: begin
            if (in_valid && ready_q) begin
               state_d = SHIFT;
               cnt_d   = CNT_W'(ITER - 1);
               bin_d   = inp;
               tens_d  = 2'b00;
               units_d = 4'b0000;
               ready_d = 1'b0;
            end else begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end

         SHIFT: begin
            tens_d  = tens_next_s[1:0];
            units_d = units_next_s;
            bin_d   = bin_next_s;
            if (cnt_q == {CNT_W{1'b0}}) begin
               // Final shift: publish the result and reopen the handshake in
               // the same cycle the pulse is visible.
               state_d     = IDLE;
               ready_d     = 1'b1;
               out_valid_d = 1'b1;
               ovf_d       = ovf_next_s;
               if (ovf_next_s) begin
                  out_d = SAT_VALUE;
               end else begin
                  out_d = {tens_next_s[0], units_next_s};
               end
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end

         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         tens_q      <= 2'b00;
         units_q     <= 4'b0000;
         bin_q       <= {IN_W{1'b0}};
         ready_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= {OUT_W{1'b0}};
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tens_q      <= tens_d;
         units_q     <= units_d;
         bin_q       <= bin_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
      end
   end

   assign ready     = ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign ovf       = ovf_q;

endmodule : binary_bcd

// File: tb/tb_binary_bcd.sv
// -----------------------------------------------------------------------------
// tb_binary_bcd
// Directed self-checking bench for binary_bcd. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled at that same point, away from
// the active edge.
// -----------------------------------------------------------------------------
module tb_binary_bcd;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [4:0] inp;
   logic       ready;
   logic       out_valid;
   logic [4:0] out;
   logic       ovf;

   int n_checks;
   int n_fail;

   binary_bcd dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inp       (inp),
      .ready     (ready),
      .out_valid (out_valid),
      .out       (out),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits up to 'limit' edges for out_valid; returns edges waited.
   task automatic wait_valid(input int limit, output int cyc);
      cyc = 0;
      while (!out_valid && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   // One complete request; checks latency, result, flag and single pulse.
   task automatic convert(input string tag, input logic [4:0] v,
                          input logic [4:0] exp_out, input logic exp_ovf);
      int cyc;
      check_eq({tag, "_ready"}, ready, 1'b1);
      in_valid = 1'b1;
      inp      = v;
      tick();                       // E0: accepted
      in_valid = 1'b0;
      inp      = ~v;                // must not disturb the conversion
      check_eq({tag, "_busy"}, ready, 1'b0);
      wait_valid(20, cyc);
      check_eq({tag, "_lat"}, cyc, 5);
      check_eq({tag, "_out"}, out, exp_out);
      check_eq({tag, "_ovf"}, ovf, exp_ovf);
      check_eq({tag, "_rdy_done"}, ready, 1'b1);
      tick();
      check_eq({tag, "_pulse"}, out_valid, 1'b0);
      check_eq({tag, "_hold"}, out, exp_out);
   endtask

   initial begin
      int cyc;
      int pulses;
      logic [4:0] exp_v;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      inp      = 5'd0;

      // Reset
      tick();
      tick();
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_out", out, 5'd0);
      check_eq("rst_ovf", ovf, 1'b0);
      rst = 1'b0;
      tick();

      // Sweep 0..19: tens bit set from 10 upward, units = value mod 10
      for (int i = 0; i < 20; i++) begin
         if (i >= 10) exp_v = 5'(16 + i - 10);
         else         exp_v = 5'(i);
         convert($sformatf("sweep%0d", i), 5'(i), exp_v, 1'b0);
      end

      // Hand-written boundary points
      convert("b9",  5'd9,  5'b0_1001, 1'b0);
      convert("b10", 5'd10, 5'b1_0000, 1'b0);
      convert("b19", 5'd19, 5'b1_1001, 1'b0);

      // Overflow saturation, then recovery
      convert("ov20", 5'd20, 5'b1_1001, 1'b1);
      convert("ov25", 5'd25, 5'b1_1001, 1'b1);
      convert("ov31", 5'd31, 5'b1_1001, 1'b1);
      convert("rec7", 5'd7,  5'b0_0111, 1'b0);

      // Latency and busy: second request at E2 is dropped
      in_valid = 1'b1;
      inp      = 5'd13;
      tick();                       // E0
      in_valid = 1'b0;
      tick();                       // E1
      in_valid = 1'b1;
      inp      = 5'd4;
      tick();                       // E2, busy
      in_valid = 1'b0;
      cyc = 2;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check_eq("busy_lat", cyc, 5);
      check_eq("busy_out", out, 5'b1_0011);
      check_eq("busy_ovf", ovf, 1'b0);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid) pulses++;
      end
      check_eq("busy_no_2nd", pulses, 0);
      check_eq("busy_hold", out, 5'b1_0011);

      // Back-to-back: 16 presented in the out_valid cycle of 11
      in_valid = 1'b1;
      inp      = 5'd11;
      tick();                       // E0
      wait_valid(20, cyc);
      check_eq("b2b_lat1", cyc, 5);
      check_eq("b2b_out1", out, 5'b1_0001);
      check_eq("b2b_rdy", ready, 1'b1);
      inp = 5'd16;
      tick();                       // E6: second request accepted
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check_eq("b2b_gap", cyc, 6);
      check_eq("b2b_out2", out, 5'b1_0110);
      check_eq("b2b_ovf2", ovf, 1'b0);
      tick();
      check_eq("b2b_single", out_valid, 1'b0);

      // Reset mid-conversion
      in_valid = 1'b1;
      inp      = 5'd18;
      tick();                       // E0
      in_valid = 1'b0;
      tick();                       // E1
      tick();                       // E2
      rst = 1'b1;
      tick();                       // E3: reset sampled
      rst = 1'b0;
      check_eq("mid_out", out, 5'd0);
      check_eq("mid_ovf", ovf, 1'b0);
      check_eq("mid_ready", ready, 1'b1);
      check_eq("mid_valid", out_valid, 1'b0);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid) pulses++;
      end
      check_eq("mid_no_valid", pulses, 0);
      check_eq("mid_out_after", out, 5'd0);

      // Usable again after the abort
      convert("post", 5'd13, 5'b1_0011, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_binary_bcd
